vocab_word_matcher: RTL and testbench
=====================================

Name: vocab_word_matcher

Overview:
- Looks up one query word in a vocabulary held in an external synchronous read memory.
- The vocabulary is stored as null-terminated words, packed back-to-back; an empty word (null at word start) ends the list.
- Generalises the earlier single-word matcher:
  - start/busy/done handshake;
  - reports the matching word index and start address;
  - the memory port is external and the sizes are parametrised.
- Sits between the tokenizer front end and the embedding-address lookup.

Parameters:
- DATA_WIDTH, 8, bits per character; character value 0 is the terminator.
- ADDR_WIDTH, 4, vocabulary memory address width (depth 2**ADDR_WIDTH).
- MAX_WORD_LEN, 3, maximum query length in characters.
- IDX_WIDTH, 4, width of the word-index counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a lookup; sampled only when busy=0
- word  in  MAX_WORD_LEN*DATA_WIDTH  query; char k = word[k*DATA_WIDTH +: DATA_WIDTH]; char 0 in LSBs
- vocab_rd_en  out  1  memory read strobe
- vocab_addr  out  ADDR_WIDTH  memory read address
- vocab_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after vocab_rd_en
- busy  out  1  lookup in progress
- done  out  1  one-cycle pulse, lookup finished
- found  out  1  result valid from done; held until next accepted start
- match_idx  out  IDX_WIDTH  index of matching vocabulary word (0-based)
- match_addr  out  ADDR_WIDTH  address of first character of matching word

Behaviour:
- Reset values: every output 0; state IDLE. Reset asserted mid-lookup aborts it: no done pulse, results cleared.
- Query capture:
  - word is registered on the accepted start; later changes to the port are ignored.
  - Query chars at k >= MAX_WORD_LEN compare as 0.
- Registers: addr (scan address), k (char position), idx (word index), wstart (current word start address).
- IDLE:
  - On start: latch word; clear addr, k, idx, wstart, found, match_idx, match_addr; busy<=1.
  - If query char 0 == 0, go to DONE with found=0. Otherwise go to RD.
- RD: vocab_rd_en=1, vocab_addr=addr; next state CMP.
- CMP: v = vocab_rdata, q = query char k.
  - v==0 and k==0: end of vocabulary; found=0, go to DONE.
  - v==q and v==0: match; found=1, match_idx=idx, match_addr=wstart, go to DONE.
  - v==q and v!=0: k++, addr++, go to RD.
  - v!=q and v==0: next word; idx++, k=0, addr++, wstart=addr+1, go to RD.
  - v!=q and v!=0: addr++, go to SKIP_RD.
- SKIP_RD / SKIP_CMP:
  - Read consecutive addresses until a null character is read.
  - On that null: idx++, k=0, wstart=addr+1, addr++, go to RD.
  - A null read at k==0 is never reached from SKIP.
- Boundaries:
  - Address overflow: any CMP or SKIP_CMP at addr == 2**ADDR_WIDTH-1 that does not resolve as a match → found=0, DONE. addr never wraps.
  - Index overflow: if idx would increment past 2**IDX_WIDTH-1 → found=0, DONE.
- DONE: done=1 for one cycle; busy<=0; return to IDLE. found, match_idx and match_addr hold their values.
- Handshake: start while busy=1 is ignored. start in the same cycle as done is ignored; it is accepted only from IDLE.
- Timing:
  - Each character read costs 2 cycles.
  - For N reads, done is high in the cycle after clock edge E0+2N, where E0 is the edge that samples start.
  - Empty query: done high after edge E0+1.

Optional Feature:
- MATCHER_NOCASE_EN defined:
  - Both v and q are folded to lower case before every equality test in CMP: ASCII 'A'..'Z' (0x41..0x5A) map to +0x20.
  - Applies only when DATA_WIDTH >= 8.
  - Null detection always uses the raw value.
- Undefined: exact bitwise compare.

Test Plan:
- Vocab "cat\0dog\0\0" at addr 0, query "dog" (no null, MAX_WORD_LEN=3) → 8 reads, done after E0+16, found=1, match_idx=1, match_addr=4.
- Same vocab, query "cow" → SKIP over "cat", mismatch in "dog", end marker at addr 8 → found=0, done after E0+18.
- Query with char 0 == 0 → no vocab_rd_en asserted, done after E0+1, found=0.
- Vocab of 16 non-null chars, query "xyz" absent → addr stops at 15, found=0, vocab_addr never wraps to 0.
- start pulsed while busy, then rst_n low mid-scan → second start ignored; after reset busy=0, done=0, found=0, match_idx=0; a fresh start then completes normally.
- MATCHER_NOCASE_EN, vocab "Cat\0\0", query "cAT" → found=1, match_idx=0; without the macro → found=0.

Source files
------------

// File: rtl/vocab_word_matcher.sv
// Looks up a query word among null-terminated words held in an external sync-read memory.
// Define MATCHER_NOCASE_EN for ASCII case-insensitive character comparison.
module vocab_word_matcher #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int MAX_WORD_LEN = 3,
   parameter int IDX_WIDTH    = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word,
   output logic                               vocab_rd_en,
   output logic [ADDR_WIDTH-1:0]              vocab_addr,
   input  logic [DATA_WIDTH-1:0]              vocab_rdata,
   output logic                               busy,
   output logic                               done,
   output logic                               found,
   output logic [IDX_WIDTH-1:0]               match_idx,
   output logic [ADDR_WIDTH-1:0]              match_addr
);
   localparam int KW = $clog2(MAX_WORD_LEN + 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
   localparam logic [IDX_WIDTH-1:0]  IDX_LAST  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EMPTY,
      S_RD,
      S_CMP,
      S_SKIP_RD,
      S_SKIP_CMP,
      S_DONE
   } state_t;

   state_t                             state_q, state_d;
   logic [MAX_WORD_LEN*DATA_WIDTH-1:0] query_q, query_d;
   logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]              wstart_q, wstart_d;
   logic [ADDR_WIDTH-1:0]              match_addr_q, match_addr_d;
   logic [KW-1:0]                      k_q, k_d;
   logic [IDX_WIDTH-1:0]               idx_q, idx_d;
   logic [IDX_WIDTH-1:0]               match_idx_q, match_idx_d;
   logic                               busy_q, busy_d;
   logic                               found_q, found_d;

   logic [DATA_WIDTH-1:0] q_char;
   logic                  v_null;
   logic                  chars_eq;
   logic                  at_last_addr;
   logic                  advance_word;

   function automatic logic [DATA_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] c);
`ifdef MATCHER_NOCASE_EN
      if (DATA_WIDTH >= 8 && c >= DATA_WIDTH'(8'h41) && c <= DATA_WIDTH'(8'h5A))
         return c + DATA_WIDTH'(8'h20);
      else
         return c;
`else
      return c;
`endif
   endfunction

   // Positions past the stored query length read back as the terminator.
   always_comb begin
      q_char = '0;
      for (int i = 0; i < MAX_WORD_LEN; i++) begin
         if (k_q == KW'(i))
            q_char = query_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign v_null       = (vocab_rdata == '0);
   assign chars_eq     = (fold(vocab_rdata) == fold(q_char));
   assign at_last_addr = (addr_q == ADDR_LAST);

   always_comb begin
      state_d      = state_q;
      query_d      = query_q;
      addr_d       = addr_q;
      wstart_d     = wstart_q;
      match_addr_d = match_addr_q;
      k_d          = k_q;
      idx_d        = idx_q;
      match_idx_d  = match_idx_q;
      busy_d       = busy_q;
      found_d      = found_q;
      advance_word = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               query_d      = word;
               addr_d       = '0;
               k_d          = '0;
               idx_d        = '0;
               wstart_d     = '0;
               found_d      = 1'b0;
               match_idx_d  = '0;
               match_addr_d = '0;
               busy_d       = 1'b1;
               state_d      = (word[DATA_WIDTH-1:0] == '0) ? S_EMPTY : S_RD;
            end
         end
         S_EMPTY: state_d = S_DONE;
         S_RD:    state_d = S_CMP;
         S_CMP: begin
            if (v_null && k_q == '0) begin
               state_d = S_DONE;
            end else if (chars_eq && v_null) begin
               found_d      = 1'b1;
               match_idx_d  = idx_q;
               match_addr_d = wstart_q;
               state_d      = S_DONE;
            end else if (chars_eq) begin
               if (at_last_addr) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + KW'(1);
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  state_d = S_RD;
               end
            end else if (v_null) begin
               advance_word = 1'b1;
            end else if (at_last_addr) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_WIDTH'(1);
               state_d = S_SKIP_RD;
            end
         end
         S_SKIP_RD: state_d = S_SKIP_CMP;
         S_SKIP_CMP: begin
            if (v_null) begin
               advance_word = 1'b1;
            end else if (at_last_addr) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_WIDTH'(1);
               state_d = S_SKIP_RD;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Moving to the next word stops the scan rather than wrap address or index.
      if (advance_word) begin
         if (at_last_addr || idx_q == IDX_LAST) begin
            state_d = S_DONE;
         end else begin
            idx_d    = idx_q + IDX_WIDTH'(1);
            k_d      = '0;
            addr_d   = addr_q + ADDR_WIDTH'(1);
            wstart_d = addr_q + ADDR_WIDTH'(1);
            state_d  = S_RD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         query_q      <= '0;
         addr_q       <= '0;
         wstart_q     <= '0;
         match_addr_q <= '0;
         k_q          <= '0;
         idx_q        <= '0;
         match_idx_q  <= '0;
         busy_q       <= 1'b0;
         found_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         query_q      <= query_d;
         addr_q       <= addr_d;
         wstart_q     <= wstart_d;
         match_addr_q <= match_addr_d;
         k_q          <= k_d;
         idx_q        <= idx_d;
         match_idx_q  <= match_idx_d;
         busy_q       <= busy_d;
         found_q      <= found_d;
      end
   end

   assign vocab_rd_en = (state_q == S_RD) || (state_q == S_SKIP_RD);
   assign vocab_addr  = addr_q;
   assign busy        = busy_q;
   assign done        = (state_q == S_DONE);
   assign found       = found_q;
   assign match_idx   = match_idx_q;
   assign match_addr  = match_addr_q;

endmodule

// File: tb/tb_vocab_word_matcher.sv
// Scoreboard bench for vocab_word_matcher: a string-level reference model predicts each
// lookup's result, read count and latency; a monitor checks them when done pulses.
module tb_vocab_word_matcher;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int ML    = 3;
   localparam int IW    = 4;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [ML*DW-1:0] word = '0;
   logic             vocab_rd_en;
   logic [AW-1:0]    vocab_addr;
   logic [DW-1:0]    vocab_rdata = '0;
   logic             busy;
   logic             done;
   logic             found;
   logic [IW-1:0]    match_idx;
   logic [AW-1:0]    match_addr;

   logic [DW-1:0] mem [DEPTH];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int word_starts[$];

   typedef struct {
      bit found;
      int idx;
      int addr;
      int reads;
      int lat;
      int e0;
   } exp_t;
   exp_t sb[$];

   vocab_word_matcher #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .MAX_WORD_LEN(ML),
      .IDX_WIDTH   (IW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .word       (word),
      .vocab_rd_en(vocab_rd_en),
      .vocab_addr (vocab_addr),
      .vocab_rdata(vocab_rdata),
      .busy       (busy),
      .done       (done),
      .found      (found),
      .match_idx  (match_idx),
      .match_addr (match_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (vocab_rd_en) vocab_rdata <= mem[vocab_addr];

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic byte unsigned fold_c(input byte unsigned c);
`ifdef MATCHER_NOCASE_EN
      if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
`endif
      return c;
   endfunction

   function automatic bit same_word(input byte unsigned a[$], input byte unsigned b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[i]) if (fold_c(a[i]) != fold_c(b[i])) return 1'b0;
      return 1'b1;
   endfunction

   // Reference: split memory into words, compare as strings. Every word visited costs
   // its length plus its null; the scan ends at the end marker or the last address.
   function automatic exp_t model(input logic [ML*DW-1:0] w);
      exp_t e;
      byte unsigned q[$];
      byte unsigned wq[$];
      int pos, widx, wstart;
      e.found = 1'b0; e.idx = 0; e.addr = 0; e.reads = 0; e.lat = 1; e.e0 = 0;
      for (int k = 0; k < ML; k++) begin
         if (w[k*DW +: DW] == '0) break;
         q.push_back(w[k*DW +: DW]);
      end
      if (q.size() == 0) return e;
      pos = 0;
      widx = 0;
      e.reads = DEPTH;
      while (pos < DEPTH) begin
         if (mem[pos] == '0) begin
            e.reads = pos + 1;
            break;
         end
         wstart = pos;
         wq.delete();
         while (pos < DEPTH && mem[pos] != '0) begin
            wq.push_back(mem[pos]);
            pos++;
         end
         if (pos == DEPTH) break;
         if (same_word(q, wq)) begin
            e.found = 1'b1;
            e.idx   = widx;
            e.addr  = wstart;
            e.reads = pos + 1;
            break;
         end
         pos++;
         widx++;
      end
      e.lat = 2 * e.reads;
      return e;
   endfunction

   // Monitor: every read must hit the next consecutive address from 0.
   int   rd_cnt = 0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst_n) begin
         rd_cnt = 0;
      end else begin
         if (vocab_rd_en) begin
            chk("rd_addr", vocab_addr, rd_cnt);
            rd_cnt++;
         end
         if (done) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1, expected no lookup pending (t=%0t)", $time);
            end else begin
               mon_e = sb.pop_front();
               $display("lookup: found=%0d idx=%0d addr=%0d reads=%0d lat=%0d (exp %0d/%0d/%0d/%0d/%0d)",
                        found, match_idx, match_addr, rd_cnt, cyc - mon_e.e0,
                        mon_e.found, mon_e.idx, mon_e.addr, mon_e.reads, mon_e.lat);
               chk("found", found, mon_e.found);
               chk("match_idx", match_idx, mon_e.idx);
               chk("match_addr", match_addr, mon_e.addr);
               chk("reads", rd_cnt, mon_e.reads);
               chk("latency", cyc - mon_e.e0, mon_e.lat);
            end
            rd_cnt = 0;
         end
      end
   end

   function automatic logic [ML*DW-1:0] mk_word(input string s);
      logic [ML*DW-1:0] w;
      byte unsigned c;
      w = '0;
      for (int k = 0; k < ML && k < s.len(); k++) begin
         c = s[k];
         w[k*DW +: DW] = (c == 8'h2E) ? 8'h00 : c;
      end
      return w;
   endfunction

   task automatic load(input string s);
      byte unsigned c;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < s.len()) begin
            c = s[i];
            mem[i] = (c == 8'h2E) ? 8'h00 : c;
         end else begin
            mem[i] = 8'h7A;
         end
      end
   endtask

   function automatic byte unsigned rand_char();
      case ($urandom_range(0, 4))
         0: return 8'h61;
         1: return 8'h62;
         2: return 8'h63;
         3: return 8'h41;
         default: return 8'h42;
      endcase
   endfunction

   task automatic rand_mem();
      int pos, len;
      word_starts.delete();
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_char();
      if ($urandom_range(0, 7) == 0) return;
      pos = 0;
      forever begin
         len = $urandom_range(1, 3);
         if (pos + len + 1 > DEPTH - 1) break;
         word_starts.push_back(pos);
         for (int j = 0; j < len; j++) mem[pos + j] = rand_char();
         mem[pos + len] = '0;
         pos += len + 1;
      end
      if ($urandom_range(0, 5) != 0) mem[pos] = '0;
   endtask

   function automatic logic [ML*DW-1:0] rand_query();
      logic [ML*DW-1:0] w;
      int r, p, len;
      w = '0;
      r = $urandom_range(0, 9);
      if (r == 0) return w;
      if (r < 6 && word_starts.size() > 0) begin
         p = word_starts[$urandom_range(0, word_starts.size() - 1)];
         for (int k = 0; k < ML && p + k < DEPTH; k++) begin
            if (mem[p + k] == '0) break;
            w[k*DW +: DW] = mem[p + k];
            if ($urandom_range(0, 3) == 0) w[k*DW +: DW] = mem[p + k] ^ 8'h20;
         end
      end else begin
         len = $urandom_range(1, 3);
         for (int k = 0; k < len; k++) w[k*DW +: DW] = rand_char();
      end
      return w;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_found"}, found, 0);
      chk({tag, "_match_idx"}, match_idx, 0);
      chk({tag, "_match_addr"}, match_addr, 0);
      chk({tag, "_rd_en"}, vocab_rd_en, 0);
   endtask

   // extra: pulse start again while busy; at_done: pulse start during the done cycle.
   task automatic lookup(input logic [ML*DW-1:0] w, input bit extra, input bit at_done);
      exp_t e;
      int n;
      e = model(w);
      @(negedge clk);
      start = 1'b1;
      word  = w;
      e.e0  = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      word  = rand_query();
      start = extra;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n == 100) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done in 100 cycles, expected latency %0d", e.lat);
         sb.delete();
      end
      if (at_done) begin
         start = 1'b1;
         word  = rand_query();
      end
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      load("cat.dog..");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("reset");

      lookup(mk_word("dog"), 1'b0, 1'b0);
      lookup(mk_word("cow"), 1'b1, 1'b0);
      lookup(mk_word("cat"), 1'b0, 1'b1);
      lookup(mk_word(""), 1'b0, 1'b0);
      lookup(mk_word("do"), 1'b0, 1'b0);

      load("abcdefghijklmnop");
      lookup(mk_word("xyz"), 1'b0, 1'b0);
      lookup(mk_word("abc"), 1'b0, 1'b0);

      load("ab.bc.ca.abc.cb.");
      lookup(mk_word("cb"), 1'b0, 1'b0);

      load("Cat..");
      lookup(mk_word("cAT"), 1'b0, 1'b0);

      // Abort a lookup with reset after a found result, with an ignored second start.
      load("cat.dog..");
      lookup(mk_word("dog"), 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      word  = mk_word("cow");
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      word  = mk_word("cat");
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("abort");
      lookup(mk_word("cat"), 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         rand_mem();
         lookup(rand_query(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
